spart_fifo_bus_intf: RTL and testbench
======================================

Name: spart_fifo_bus_intf

Overview:
Second-generation SPART bus interface between the processor I/O bus and the SPART transmitter, receiver and baud generator.
- Adds parametrised RX and TX FIFOs so bytes are not lost between processor accesses.
- Adds sticky error flags and a 16-bit baud divisor register with readback.
- Drives the shared tri-state databus on reads only; the transmit and receive serial engines are separate blocks.

Parameters:
DATA_W, 8, width of databus, data registers and FIFO entries (>=6, so all status bits fit)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
BAUD_RST, 16'd325, divisor value loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  reset
iocs  in  1  chip select; one bus access per cycle it is high
iorw  in  1  1 = read, 0 = write
ioaddr  in  2  register select
databus  inout  DATA_W  processor data bus
rx_data  in  DATA_W  byte from receiver
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
tx_data  out  DATA_W  byte to transmitter (TX FIFO head)
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  transmitter accepts tx_data this cycle
baud_div  out  16  current divisor
baud_load  out  1  one-cycle pulse after any divisor write

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high; all state clears on a clk edge with rst=1.
- Reset values:
  - FIFOs empty, pointers 0; tx_valid=0, tx_data=0.
  - baud_div=BAUD_RST, baud_load=0.
  - rx_overrun=0, tx_overflow=0.
  - databus is Z.
- Address map:
  - 00 read: pop RX FIFO. Databus shows the head combinationally (show-ahead); pointer advances at the edge.
  - 00 write: push databus into TX FIFO.
  - 01 read: status register. Reading it clears both sticky bits at that edge. Write to 01 is ignored.
  - 10: baud divisor low byte (baud_div[7:0]), read/write.
  - 11: baud divisor high byte (baud_div[15:8]), read/write.
- Status bits:
  - [0] rx_not_empty; [1] tx_not_full; [2] rx_overrun (sticky); [3] tx_empty; [4] rx_full; [5] tx_overflow (sticky).
  - Upper bits 0.
- Databus drive: only when iocs&&iorw; Z otherwise. Read of empty RX FIFO at 00 returns 0; pointers unchanged.
- RX push:
  - rx_valid pushes rx_data.
  - If full and no pop in the same cycle, the byte is dropped and rx_overrun is set.
  - If full and a pop occurs in the same cycle, push and pop both complete; no overrun.
  - If a status read clears rx_overrun in the same cycle a new overrun occurs, set wins.
- TX push:
  - Write to 00 when full drops the byte and sets tx_overflow.
  - Simultaneous push and drain when full: both complete.
  - Set-wins rule applies to tx_overflow vs status-read clear.
- TX drain: tx_data = head and tx_valid = !empty, both registered-pointer based. A pop occurs on the edge where tx_valid&&tx_ready. Empty + push makes tx_valid rise the next cycle; latency write-to-tx_valid is 1 cycle.
- Baud: a write to 10/11 updates the byte at the edge. baud_load is 1 in the following cycle; back-to-back writes give a pulse each.
- FIFO counts use log2(depth)+1-bit occupancy; pointers wrap modulo depth.
- Reset mid-operation: FIFO contents are discarded and pointers zeroed; a partially transmitted byte is the transmitter's concern.

Decomposition:
- Shared package/include spart_defs: address constants (ADDR_DATA, ADDR_STATUS, ADDR_DBL, ADDR_DBH) and status bit indices. Transmitter and receiver reuse them.
- Sub-module spart_sync_fifo (params WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, count), instantiated once for RX and once for TX. Push and pop are gated internally, so a push to a full FIFO or a pop from an empty one has no effect.

Test Plan:
- Reset then status read -> databus=8'h0A (tx_not_full, tx_empty), baud_div=325, tx_valid=0.
- Pulse rx_valid with 8'h41, 8'h42, then two reads at 00 -> databus 8'h41, then 8'h42; third read returns 8'h00; status bit0=0.
- Nine rx_valid pulses with no reads (RX_DEPTH=8) -> status=8'h1F (rx_full, rx_overrun); next status read=8'h1F, following read=8'h1B (overrun cleared); data reads yield first 8 bytes in order.
- tx_ready=0, write 8'h55 x9 -> tx_overflow set, status bit1=0. Then tx_ready=1 -> eight consecutive cycles of tx_data=8'h55; tx_valid falls after the 8th.
- Write 8'h16 to 10 and 8'h01 to 11 -> baud_div=16'h0116, one baud_load pulse after each write; readback at 10/11 returns 8'h16/8'h01.
- RX full plus simultaneous rx_valid and 00 read -> no overrun, count stays 8; assert rst mid-burst -> next cycle all reset values hold.

Source files
------------

// File: rtl/spart_defs.sv
// spart_defs
//   Shared definitions for the SPART bus interface, transmitter and receiver.
//   Holds the processor-visible register addresses and the bit positions of
//   the status register, so every SPART block decodes the map identically.
package spart_defs;

    // Register map selected by ioaddr
    localparam logic [1:0] ADDR_DATA   = 2'b00;  // RX pop on read, TX push on write
    localparam logic [1:0] ADDR_STATUS = 2'b01;  // status (read clears sticky bits)
    localparam logic [1:0] ADDR_DBL    = 2'b10;  // baud divisor [7:0]
    localparam logic [1:0] ADDR_DBH    = 2'b11;  // baud divisor [15:8]

    // Status register bit positions; unlisted upper bits read as 0
    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_RX_OVERRUN   = 2;  // sticky
    localparam int ST_TX_EMPTY     = 3;
    localparam int ST_RX_FULL      = 4;
    localparam int ST_TX_OVERFLOW  = 5;  // sticky

endpackage

// File: rtl/spart_sync_fifo.sv
// spart_sync_fifo
//   Single-clock show-ahead FIFO used for both the SPART RX and TX paths.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push, wdata     write request and data
//     pop             read request; rdata is the current head
//     rdata           head entry, 0 while empty
//     full, empty     occupancy flags
//     count           occupancy, $clog2(DEPTH)+1 bits
//   A push while full only completes if a pop completes in the same cycle;
//   a pop while empty is ignored.
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // Full plus a completing pop frees the slot we are about to write
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH (power of 2)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_fifo_bus_intf.sv
// spart_fifo_bus_intf
//   Processor-side register interface of the SPART with RX/TX FIFOs,
//   sticky error flags and a 16-bit baud divisor.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     iocs, iorw, ioaddr       bus access strobe, 1=read/0=write, register select
//     databus                  shared tri-state bus, driven only during reads
//     rx_data, rx_valid        byte strobe from the receiver into the RX FIFO
//     tx_data, tx_valid,
//     tx_ready                 TX FIFO head to the transmitter
//     baud_div, baud_load      divisor and one-cycle pulse after a divisor write
module spart_fifo_bus_intf #(
    parameter int          DATA_W   = 8,
    parameter int          RX_DEPTH = 8,
    parameter int          TX_DEPTH = 8,
    parameter logic [15:0] BAUD_RST = 16'd325
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [15:0]       baud_div,
    output logic              baud_load
);

    import spart_defs::*;

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic              bus_rd;
    logic              bus_wr;
    logic              rx_pop;
    logic              tx_push;
    logic              stat_rd;
    logic              rx_full;
    logic              rx_empty;
    logic              tx_full;
    logic              tx_empty;
    logic [RX_CW-1:0]  rx_count;
    logic [TX_CW-1:0]  tx_count;
    logic [DATA_W-1:0] rx_head;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_data;
    logic              rx_overrun;
    logic              tx_overflow;
    logic              rx_overrun_set;
    logic              tx_overflow_set;
    logic [7:0]        wr_byte;

    assign bus_rd  = iocs && iorw;
    assign bus_wr  = iocs && !iorw;
    assign rx_pop  = bus_rd && (ioaddr == ADDR_DATA);
    assign tx_push = bus_wr && (ioaddr == ADDR_DATA);
    assign stat_rd = bus_rd && (ioaddr == ADDR_STATUS);
    assign wr_byte = 8'(databus);

    spart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX handshake: a byte transfers on every edge where tx_valid && tx_ready;
    // tx_data holds steady while tx_valid is high and tx_ready is low.
    spart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_ready),
        .wdata (databus),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid = !tx_empty;

    // A full FIFO is never empty, so a requested pop always completes and
    // makes room for the simultaneous push.
    assign rx_overrun_set  = rx_valid && rx_full && !rx_pop;
    assign tx_overflow_set = tx_push && tx_full && !tx_ready;

    // Sticky flags: a new error in the clearing cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (rx_overrun_set)  rx_overrun <= 1'b1;
            else if (stat_rd)    rx_overrun <= 1'b0;
            if (tx_overflow_set) tx_overflow <= 1'b1;
            else if (stat_rd)    tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div  <= BAUD_RST;
            baud_load <= 1'b0;
        end else begin
            baud_load <= bus_wr && ((ioaddr == ADDR_DBL) || (ioaddr == ADDR_DBH));
            if (bus_wr && (ioaddr == ADDR_DBL)) baud_div[7:0]  <= wr_byte;
            if (bus_wr && (ioaddr == ADDR_DBH)) baud_div[15:8] <= wr_byte;
        end
    end

    always_comb begin
        status                  = '0;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_NOT_FULL]  = (tx_count != TX_CW'(TX_DEPTH));
        status[ST_RX_OVERRUN]   = rx_overrun;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_FULL]      = (rx_count == RX_CW'(RX_DEPTH));
        status[ST_TX_OVERFLOW]  = tx_overflow;
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            ADDR_DATA:   rd_data = rx_head;  // 0 when RX FIFO is empty
            ADDR_STATUS: rd_data = status;
            ADDR_DBL:    rd_data = DATA_W'(baud_div[7:0]);
            ADDR_DBH:    rd_data = DATA_W'(baud_div[15:8]);
            default:     rd_data = '0;
        endcase
    end

    assign databus = bus_rd ? rd_data : 'z;

endmodule

// File: tb/tb_spart_fifo_bus_intf.sv
// tb_spart_fifo_bus_intf
//   Directed bench for spart_fifo_bus_intf with DATA_W=8, RX/TX depth 8.
module tb_spart_fifo_bus_intf;

    logic        clk;
    logic        rst;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic [7:0]  bus_drv;
    logic        bus_oe;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] baud_div;
    logic        baud_load;

    int vectors;
    int miscompares;

    assign databus = bus_oe ? bus_drv : 'z;

    spart_fifo_bus_intf #(
        .DATA_W   (8),
        .RX_DEPTH (8),
        .TX_DEPTH (8),
        .BAUD_RST (16'd325)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .baud_div  (baud_div),
        .baud_load (baud_load)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers: each starts 1 time unit after an edge and returns 1 after the next
    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(posedge clk); #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a;
        bus_oe = 1'b1; bus_drv = v;
        @(posedge clk); #1;
        iocs = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] v);
        rx_valid = 1'b1; rx_data = v;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        vectors = 0; miscompares = 0;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        bus_oe = 1'b0; bus_drv = 8'h00; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_baud_div", baud_div, 16'd325);
        check("rst_baud_load", baud_load, 0);
        bus_read(2'b01, d); check("rst_status", d, 8'h0A);

        // Write to status is ignored
        bus_write(2'b01, 8'hFF);
        check("st_wr_no_load", baud_load, 0);
        bus_read(2'b01, d); check("st_wr_status", d, 8'h0A);

        // RX basic
        rx_push(8'h41); rx_push(8'h42);
        bus_read(2'b01, d); check("rx2_status", d, 8'h0B);
        bus_read(2'b00, d); check("rx_rd0", d, 8'h41);
        bus_read(2'b00, d); check("rx_rd1", d, 8'h42);
        bus_read(2'b00, d); check("rx_rd_empty", d, 8'h00);
        bus_read(2'b01, d); check("rx_drained_status", d, 8'h0A);

        // RX overrun
        for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
        bus_read(2'b01, d); check("ovr_status", d, 8'h1F);
        bus_read(2'b01, d); check("ovr_cleared", d, 8'h1B);
        // New overrun during the clearing status read: set wins
        rx_valid = 1'b1; rx_data = 8'h99;
        bus_read(2'b01, d);
        rx_valid = 1'b0;
        check("setwin_during", d, 8'h1B);
        bus_read(2'b01, d); check("setwin_after", d, 8'h1F);
        bus_read(2'b01, d); check("setwin_clear", d, 8'h1B);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'b00, d); check($sformatf("ovr_rd%0d", i), d, 8'h10 + 8'(i));
        end
        bus_read(2'b01, d); check("ovr_drained", d, 8'h0A);

        // TX overflow and drain
        check("tx_idle_valid", tx_valid, 0);
        bus_write(2'b00, 8'h55);
        check("tx_latency_valid", tx_valid, 1);
        check("tx_latency_data", tx_data, 8'h55);
        for (int i = 0; i < 8; i++) bus_write(2'b00, 8'h55);
        bus_read(2'b01, d); check("tx_ovf_status", d, 8'h20);
        bus_read(2'b01, d); check("tx_ovf_cleared", d, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_drain%0d", i), {tx_valid, tx_data}, 9'h155);
            @(posedge clk); #1;
        end
        check("tx_drained_valid", tx_valid, 0);
        tx_ready = 1'b0;
        bus_read(2'b01, d); check("tx_drained_status", d, 8'h0A);

        // TX ordering
        bus_write(2'b00, 8'hA1); bus_write(2'b00, 8'hA2);
        tx_ready = 1'b1;
        check("tx_ord0", {tx_valid, tx_data}, 9'h1A1);
        @(posedge clk); #1;
        check("tx_ord1", {tx_valid, tx_data}, 9'h1A2);
        @(posedge clk); #1;
        check("tx_ord_done", tx_valid, 0);
        tx_ready = 1'b0;

        // Baud divisor
        bus_write(2'b10, 8'h16);
        check("baud_lo_load", baud_load, 1);
        check("baud_lo_div", baud_div, 16'h0116);
        bus_write(2'b11, 8'h01);
        check("baud_hi_load", baud_load, 1);
        check("baud_hi_div", baud_div, 16'h0116);
        @(posedge clk); #1;
        check("baud_load_end", baud_load, 0);
        bus_read(2'b10, d); check("baud_rd_lo", d, 8'h16);
        bus_read(2'b11, d); check("baud_rd_hi", d, 8'h01);
        bus_write(2'b11, 8'h3C);
        check("baud_hi2_div", baud_div, 16'h3C16);
        bus_read(2'b11, d); check("baud_rd_hi2", d, 8'h3C);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i));
        rx_valid = 1'b1; rx_data = 8'h28;
        bus_read(2'b00, d);
        rx_valid = 1'b0;
        check("full_pp_rd", d, 8'h20);
        bus_read(2'b01, d); check("full_pp_status", d, 8'h1B);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'b00, d); check($sformatf("full_pp_rd%0d", i), d, 8'h21 + 8'(i));
        end
        bus_read(2'b01, d); check("full_pp_drained", d, 8'h0A);

        // Reset mid-burst
        bus_write(2'b00, 8'h77);
        rx_push(8'h66);
        rst = 1'b1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; bus_oe = 1'b1; bus_drv = 8'h88;
        rx_valid = 1'b1; rx_data = 8'h55;
        @(posedge clk); #1;
        rst = 1'b0; iocs = 1'b0; bus_oe = 1'b0; rx_valid = 1'b0;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_baud_div", baud_div, 16'd325);
        check("mid_rst_baud_load", baud_load, 0);
        bus_read(2'b01, d); check("mid_rst_status", d, 8'h0A);
        bus_read(2'b00, d); check("mid_rst_rx_rd", d, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
